// File: rtl/uvmt_cv32e40s_obi_phase_tracker_pkg.sv
// Shared constants and types for the OBI phase tracker and the OBI stall assume/assert support logic.
package uvmt_cv32e40s_pkg;

  localparam int unsigned OBI_MAX_OUTSTANDING = 8;
  localparam int unsigned OBI_CNT_W           = 32;

  typedef struct packed {
    logic addr;         // req && gnt handshake
    logic rsp_counted;  // rvalid matched to an outstanding address phase
    logic orphan;       // rvalid with nothing outstanding
    logic overflow;     // push into a full timestamp FIFO without a pop
  } obi_ph_ev_t;

endpackage

// File: rtl/uvmt_cv32e40s_obi_ts_fifo.sv
// In-order timestamp FIFO; pops on empty are ignored, pushes on full succeed only with a concurrent pop.
module uvmt_cv32e40s_obi_ts_fifo #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned W     = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count == CW'(DEPTH));
  assign empty_o = (count == '0);
  assign rdata_o = mem[rd_ptr];

  always_comb begin
    do_pop  = pop_i && !empty_o;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    do_push = push_i && (!full_o || do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      end
      if (do_pop) begin
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uvmt_cv32e40s_obi_phase_tracker.sv
// Counts OBI address/response phases per bus and reports the age of the oldest outstanding transaction.
module uvmt_cv32e40s_obi_phase_tracker
  import uvmt_cv32e40s_pkg::*;
#(
  parameter int unsigned MAX_OUTSTANDING = OBI_MAX_OUTSTANDING,
  parameter int unsigned CNT_W           = OBI_CNT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             obi_req_i,
  input  logic             obi_gnt_i,
  input  logic             obi_rvalid_i,
  output logic [CNT_W-1:0] addr_ph_occurances_o,
  output logic [CNT_W-1:0] rsp_ph_occurances_o,
  output logic [CNT_W-1:0] outstanding_o,
  output logic [CNT_W-1:0] oldest_age_o,
  output logic             err_overflow_o,
  output logic             err_orphan_rsp_o
);

  logic [CNT_W-1:0] cycle_cnt;
  logic [CNT_W-1:0] addr_cnt;
  logic [CNT_W-1:0] rsp_cnt;
  logic [CNT_W-1:0] head_ts;
  logic             err_ovf_q;
  logic             err_orph_q;
  logic             fifo_full;
  logic             fifo_empty;
  obi_ph_ev_t       ev;

  assign outstanding_o        = addr_cnt - rsp_cnt;
  assign addr_ph_occurances_o = addr_cnt;
  assign rsp_ph_occurances_o  = rsp_cnt;
  assign err_overflow_o       = err_ovf_q;
  assign err_orphan_rsp_o     = err_orph_q;
  assign oldest_age_o         = fifo_empty ? '0 : cycle_cnt - head_ts;

  // Outstanding is judged before this cycle's grant, so a response alongside
  // the grant of the only transaction is treated as orphaned.
  always_comb begin
    ev             = '0;
    ev.addr        = obi_req_i && obi_gnt_i;
    ev.rsp_counted = obi_rvalid_i && (outstanding_o != '0);
    ev.orphan      = obi_rvalid_i && (outstanding_o == '0);
    ev.overflow    = ev.addr && fifo_full && !ev.rsp_counted;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cycle_cnt  <= '0;
      addr_cnt   <= '0;
      rsp_cnt    <= '0;
      err_ovf_q  <= 1'b0;
      err_orph_q <= 1'b0;
    end else begin
      cycle_cnt <= cycle_cnt + CNT_W'(1);
      if (ev.addr) begin
        addr_cnt <= addr_cnt + CNT_W'(1);
      end
      if (ev.rsp_counted) begin
        rsp_cnt <= rsp_cnt + CNT_W'(1);
      end
      if (ev.overflow) begin
        err_ovf_q <= 1'b1;
      end
      if (ev.orphan) begin
        err_orph_q <= 1'b1;
      end
    end
  end

  uvmt_cv32e40s_obi_ts_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .W     (CNT_W)
  ) u_ts_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (ev.addr),
    .pop_i   (ev.rsp_counted),
    .wdata_i (cycle_cnt),
    .rdata_o (head_ts),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

endmodule

// File: tb/tb_uvmt_cv32e40s_obi_phase_tracker.sv
// Directed table-driven bench for the OBI phase tracker plus multi-cycle corner sequences.
module tb_uvmt_cv32e40s_obi_phase_tracker;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        gnt;
  logic        rvalid;
  logic [31:0] addr_ph;
  logic [31:0] rsp_ph;
  logic [31:0] outstanding;
  logic [31:0] age;
  logic        ovf;
  logic        orph;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  uvmt_cv32e40s_obi_phase_tracker #(
    .MAX_OUTSTANDING (8),
    .CNT_W           (32)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .obi_req_i            (req),
    .obi_gnt_i            (gnt),
    .obi_rvalid_i         (rvalid),
    .addr_ph_occurances_o (addr_ph),
    .rsp_ph_occurances_o  (rsp_ph),
    .outstanding_o        (outstanding),
    .oldest_age_o         (age),
    .err_overflow_o       (ovf),
    .err_orphan_rsp_o     (orph)
  );

  typedef struct {
    logic        rst;
    logic        req;
    logic        gnt;
    logic        rv;
    logic [31:0] addr;
    logic [31:0] rsp;
    logic [31:0] out;
    logic [31:0] age;
    logic        ovf;
    logic        orph;
  } vec_t;

  vec_t vecs [12];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [31:0] e_addr, input logic [31:0] e_rsp,
                           input logic [31:0] e_out, input logic [31:0] e_age,
                           input logic e_ovf, input logic e_orph);
    check({tag, ".addr"}, addr_ph, e_addr);
    check({tag, ".rsp"},  rsp_ph, e_rsp);
    check({tag, ".out"},  outstanding, e_out);
    check({tag, ".age"},  age, e_age);
    check({tag, ".ovf"},  {31'b0, ovf}, {31'b0, e_ovf});
    check({tag, ".orph"}, {31'b0, orph}, {31'b0, e_orph});
  endtask

  // Apply inputs on the falling edge, then sample just after the capturing rising edge.
  task automatic drive(input logic r, input logic q, input logic g, input logic v);
    @(negedge clk);
    rst = r; req = q; gnt = g; rvalid = v;
    @(posedge clk);
    #1;
  endtask

  task automatic wrap_grant();
    @(negedge clk);
    dut.cycle_cnt = 32'hFFFF_FFFE;
    rst = 1'b0; req = 1'b1; gnt = 1'b1; rvalid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; req = 1'b0; gnt = 1'b0; rvalid = 1'b0;

    //        rst   req   gnt   rv    addr rsp out age ovf   orph
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 1, 0, 1, 1, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1, 2, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1, 0, 1, 3, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 0, 0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1, 1, 0, 0, 1'b0, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1, 1, 0, 0, 1'b0, 1'b1};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1, 1, 0, 0, 1'b0, 1'b1};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 2, 1, 1, 1, 1'b0, 1'b1};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b1, 2, 2, 0, 0, 1'b0, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 1'b1, 0, 0, 0, 0, 1'b0, 1'b0};

    for (int i = 0; i < 12; i++) begin
      drive(vecs[i].rst, vecs[i].req, vecs[i].gnt, vecs[i].rv);
      check_all($sformatf("vec%0d", i), vecs[i].addr, vecs[i].rsp, vecs[i].out,
                vecs[i].age, vecs[i].ovf, vecs[i].orph);
    end

    // Fill to capacity, then a simultaneous grant and response at full.
    drive(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 1, 1, 0);
    check_all("full", 8, 0, 8, 8, 1'b0, 1'b0);
    drive(0, 1, 1, 1);
    check_all("full_pushpop", 9, 1, 8, 8, 1'b0, 1'b0);

    // Overflow: 9th grant with no response, then drain past the FIFO contents.
    drive(1, 0, 0, 0);
    for (int i = 0; i < 8; i++) drive(0, 1, 1, 0);
    drive(0, 1, 1, 0);
    check_all("ovf", 9, 0, 9, 9, 1'b1, 1'b0);
    drive(0, 0, 0, 1);
    check_all("ovf_rsp1", 9, 1, 8, 9, 1'b1, 1'b0);
    for (int i = 0; i < 7; i++) drive(0, 0, 0, 1);
    check_all("ovf_fifo_empty", 9, 8, 1, 0, 1'b1, 1'b0);
    drive(0, 0, 0, 1);
    check_all("ovf_drained", 9, 9, 0, 0, 1'b1, 1'b0);
    drive(0, 0, 0, 0);
    drive(0, 0, 0, 0);
    check_all("ovf_sticky", 9, 9, 0, 0, 1'b1, 1'b0);
    drive(1, 0, 0, 0);
    check_all("ovf_reset", 0, 0, 0, 0, 1'b0, 1'b0);

    // Age across cycle-counter wrap, then reset mid-transaction.
    drive(0, 0, 0, 0);
    wrap_grant();
    check_all("wrap1", 1, 0, 1, 1, 1'b0, 1'b0);
    drive(0, 0, 0, 0);
    check("wrap2.age", age, 2);
    drive(0, 0, 0, 0);
    check("wrap3.age", age, 3);
    drive(0, 0, 0, 0);
    check_all("wrap4", 1, 0, 1, 4, 1'b0, 1'b0);
    drive(1, 1, 1, 1);
    check_all("wrap_reset", 0, 0, 0, 0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
